// File: rtl/layer_palette_mapper.sv
// Two-stage sprite/background compositor: priority-select the top opaque layer, then look it up in a writable palette.
// Latency 2 cycles, 1 pixel/cycle, no stall; define HIT_FLASH_EN for per-layer frame-counted colour inversion.
module layer_palette_mapper #(
  parameter int NUM_LAYERS   = 4,
  parameter int IDX_W        = 8,
  parameter int SPR_DEPTH    = 16,
  parameter int BG_IDX_W     = 4,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                                             Clk,
  input  logic                                             Reset_n,
  input  logic                                             pix_valid_in,
  input  logic                                             blank_in,
  input  logic [NUM_LAYERS-1:0]                            layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0]                      layer_idx,
  input  logic [BG_IDX_W-1:0]                              bg_idx,
  input  logic                                             pal_we,
  input  logic                                             pal_sel,
  input  logic [((IDX_W > BG_IDX_W) ? IDX_W : BG_IDX_W)-1:0] pal_addr,
  input  logic [3*COLOR_W-1:0]                             pal_wdata,
  input  logic                                             frame_start,
  input  logic [NUM_LAYERS-1:0]                            flash_req,
  output logic [COLOR_W-1:0]                               VGA_R,
  output logic [COLOR_W-1:0]                               VGA_G,
  output logic [COLOR_W-1:0]                               VGA_B,
  output logic                                             pix_valid_out
);

  localparam int PAL_AW   = (IDX_W > BG_IDX_W) ? IDX_W : BG_IDX_W;
  localparam int SPR_AW   = $clog2(SPR_DEPTH);
  localparam int BG_DEPTH = 1 << BG_IDX_W;
  localparam int RGB_W    = 3 * COLOR_W;
  localparam int WIN_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [PAL_AW:0] SPR_LIM     = (PAL_AW+1)'(SPR_DEPTH);
  localparam logic [PAL_AW:0] BG_LIM      = (PAL_AW+1)'(BG_DEPTH);
  localparam logic [IDX_W:0]  SPR_IDX_LIM = (IDX_W+1)'(SPR_DEPTH);

  logic [RGB_W-1:0] spr_pal_q [SPR_DEPTH];
  logic [RGB_W-1:0] bg_pal_q  [BG_DEPTH];
  logic             spr_we;
  logic             bg_we;

  assign spr_we = pal_we && !pal_sel && ({1'b0, pal_addr} < SPR_LIM);
  assign bg_we  = pal_we &&  pal_sel && ({1'b0, pal_addr} < BG_LIM);

  // Lookups read the pre-edge contents, so a same-cycle write is seen one pixel later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SPR_DEPTH; i++) spr_pal_q[i] <= '0;
      for (int i = 0; i < BG_DEPTH; i++)  bg_pal_q[i]  <= '0;
    end else begin
      if (spr_we) spr_pal_q[pal_addr[SPR_AW-1:0]]   <= pal_wdata;
      if (bg_we)  bg_pal_q[pal_addr[BG_IDX_W-1:0]] <= pal_wdata;
    end
  end

  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic [WIN_W-1:0] win_k;
  logic             win_flash;

  // Scan from lowest priority upward so the lowest-numbered opaque layer is the last to assign.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_k   = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_hit[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
        win_hit = 1'b1;
        win_idx = layer_idx[k*IDX_W +: IDX_W];
        win_k   = WIN_W'(k);
      end
    end
  end

`ifdef HIT_FLASH_EN
  localparam int FC_NEED = $clog2(FLASH_FRAMES + 1);
  localparam int FC_W    = (FC_NEED > 3) ? FC_NEED : 3;

  logic [FC_W-1:0] fc_q [NUM_LAYERS];
  logic [FC_W-1:0] fc_d [NUM_LAYERS];

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      fc_d[k] = fc_q[k];
      if (flash_req[k])
        fc_d[k] = FC_W'(FLASH_FRAMES);
      else if (frame_start && (fc_q[k] != '0))
        fc_d[k] = fc_q[k] - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_LAYERS; k++) fc_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LAYERS; k++) fc_q[k] <= fc_d[k];
    end
  end

  assign win_flash = win_hit && (fc_q[win_k] != '0);
`else
  localparam int UNUSED_FLASH_FRAMES = FLASH_FRAMES;
  logic unused_flash;
  logic [WIN_W-1:0] unused_win_k;
  assign unused_flash = ^{frame_start, flash_req};
  assign unused_win_k = win_k;
  assign win_flash    = 1'b0;
`endif

  logic                s1_vld_q;
  logic                s1_blank_q;
  logic                s1_spr_q;
  logic                s1_flash_q;
  logic [IDX_W-1:0]    s1_idx_q;
  logic [BG_IDX_W-1:0] s1_bg_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_spr_q   <= 1'b0;
      s1_flash_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_bg_q    <= '0;
    end else begin
      s1_vld_q <= pix_valid_in;
      if (pix_valid_in) begin
        s1_blank_q <= blank_in;
        s1_spr_q   <= win_hit;
        s1_flash_q <= win_flash;
        s1_idx_q   <= win_idx;
        s1_bg_q    <= bg_idx;
      end
    end
  end

  logic [RGB_W-1:0] spr_rgb;
  logic [RGB_W-1:0] rgb_d;
  logic [RGB_W-1:0] rgb_q;
  logic             vout_q;

  // Out-of-range indices render black, which a flash then turns into all-ones.
  always_comb begin
    spr_rgb = '0;
    if ({1'b0, s1_idx_q} < SPR_IDX_LIM) spr_rgb = spr_pal_q[s1_idx_q[SPR_AW-1:0]];
    if (s1_flash_q) spr_rgb = ~spr_rgb;
    rgb_d = rgb_q;
    if (s1_vld_q) begin
      if (s1_blank_q)    rgb_d = '0;
      else if (s1_spr_q) rgb_d = spr_rgb;
      else               rgb_d = bg_pal_q[s1_bg_q];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q  <= '0;
      vout_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      vout_q <= s1_vld_q;
    end
  end

  assign VGA_R         = rgb_q[RGB_W-1 -: COLOR_W];
  assign VGA_G         = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B         = rgb_q[COLOR_W-1:0];
  assign pix_valid_out = vout_q;

endmodule

// File: tb/tb_layer_palette_mapper.sv
// Bench for layer_palette_mapper: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_layer_palette_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic        blank_in = 1'b0;
  logic [3:0]  layer_hit = '0;
  logic [31:0] layer_idx = '0;
  logic [3:0]  bg_idx = '0;
  logic        pal_we = 1'b0;
  logic        pal_sel = 1'b0;
  logic [7:0]  pal_addr = '0;
  logic [23:0] pal_wdata = '0;
  logic        frame_start = 1'b0;
  logic [3:0]  flash_req = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        pix_valid_out;

  layer_palette_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in), .blank_in(blank_in),
    .layer_hit(layer_hit), .layer_idx(layer_idx), .bg_idx(bg_idx),
    .pal_we(pal_we), .pal_sel(pal_sel), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .frame_start(frame_start), .flash_req(flash_req),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .pix_valid_out(pix_valid_out)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%06h expected=%06h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: palettes, flash counters, and the two pipeline stages held as decisions.
  logic [23:0] m_spr [16];
  logic [23:0] m_bg  [16];
  int          m_fc  [4];
  typedef struct {
    bit vld; bit blank; bit spr; int idx; bit flash; int bg;
  } stage_t;
  stage_t      m_s1;
  logic [23:0] m_rgb;
  bit          m_vout;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_spr[i] = '0; m_bg[i] = '0; end
    for (int k = 0; k < 4; k++) m_fc[k] = 0;
    m_s1 = '{0, 0, 0, 0, 0, 0};
    m_rgb = '0;
    m_vout = 0;
  endtask

  function automatic logic [23:0] model_colour(stage_t s);
    logic [23:0] c;
    if (s.blank) return 24'h0;
    if (!s.spr) return m_bg[s.bg];
    c = (s.idx < 16) ? m_spr[s.idx] : 24'h0;
    if (s.flash) c = ~c;
    return c;
  endfunction

  task automatic model_edge();
    int w;
    if (m_s1.vld) m_rgb = model_colour(m_s1);
    m_vout = m_s1.vld;
    if (pix_valid_in) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && layer_hit[k] && layer_idx[k*8 +: 8] != 0) w = k;
      m_s1.blank = blank_in;
      m_s1.spr   = (w >= 0);
      m_s1.idx   = (w >= 0) ? int'(layer_idx[w*8 +: 8]) : 0;
      m_s1.bg    = int'(bg_idx);
`ifdef HIT_FLASH_EN
      m_s1.flash = (w >= 0) && (m_fc[w] != 0);
`else
      m_s1.flash = 0;
`endif
    end
    m_s1.vld = pix_valid_in;
    if (pal_we && pal_addr < 16) begin
      if (pal_sel) m_bg[pal_addr]  = pal_wdata;
      else         m_spr[pal_addr] = pal_wdata;
    end
    for (int k = 0; k < 4; k++) begin
      if (flash_req[k]) m_fc[k] = 8;
      else if (frame_start && m_fc[k] > 0) m_fc[k]--;
    end
  endtask

  function automatic logic [23:0] rgb_out();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1;
    check_val("model_rgb", {8'h0, rgb_out()}, {8'h0, m_rgb});
    check_val("model_vld", {31'h0, pix_valid_out}, {31'h0, m_vout});
  endtask

  task automatic set_pix(input bit v, input bit b, input logic [3:0] hit,
                         input logic [31:0] idx, input logic [3:0] bg);
    pix_valid_in = v; blank_in = b; layer_hit = hit; layer_idx = idx; bg_idx = bg;
  endtask

  task automatic pal_write(input bit sel, input logic [7:0] addr, input logic [23:0] d);
    pal_we = 1'b1; pal_sel = sel; pal_addr = addr; pal_wdata = d;
    cyc();
    pal_we = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_val("reset_rgb", {8'h0, rgb_out()}, 32'h0);
    check_val("reset_vld", {31'h0, pix_valid_out}, 32'h0);
    #3 Reset_n = 1'b1;

    // Background path
    pal_write(1'b0, 8'd1, 24'hFF0000);
    pal_write(1'b1, 8'd0, 24'h884048);
    set_pix(1, 0, 4'b0000, 32'h0, 4'd0);
    cyc(); cyc();
    check_val("bg0", {8'h0, rgb_out()}, 32'h884048);
    check_val("bg0_vld", {31'h0, pix_valid_out}, 32'h1);

    // Priority: transparent layer 1 loses to layer 2, then opaque layer 1 wins
    set_pix(1, 0, 4'b0110, 32'h0001_0000, 4'd0);
    cyc(); cyc();
    check_val("layer2_wins", {8'h0, rgb_out()}, 32'hFF0000);
    pal_write(1'b0, 8'd3, 24'h0000FF);
    set_pix(1, 0, 4'b0110, 32'h0001_0300, 4'd0);
    cyc(); cyc();
    check_val("layer1_wins", {8'h0, rgb_out()}, 32'h0000FF);

    // Same-cycle palette write vs lookup
    set_pix(1, 0, 4'b0001, 32'h0000_0001, 4'd0);
    cyc();
    pal_we = 1'b1; pal_sel = 1'b0; pal_addr = 8'd1; pal_wdata = 24'h00FF00;
    cyc();
    pal_we = 1'b0;
    check_val("wr_old_value", {8'h0, rgb_out()}, 32'hFF0000);
    cyc();
    check_val("wr_new_value", {8'h0, rgb_out()}, 32'h00FF00);

    // Out-of-range index, blanking, and hold while invalid
    set_pix(1, 0, 4'b0001, 32'h0000_0014, 4'd0);
    cyc(); cyc();
    check_val("idx_range_black", {8'h0, rgb_out()}, 32'h0);
    set_pix(1, 1, 4'b1111, 32'h0101_0101, 4'd0);
    cyc(); cyc();
    check_val("blank_black", {8'h0, rgb_out()}, 32'h0);
    pal_write(1'b1, 8'd16, 24'h123456);
    set_pix(1, 0, 4'b0001, 32'h0000_0001, 4'd0);
    cyc(); cyc();
    set_pix(0, 0, 4'b0000, 32'h0, 4'd0);
    cyc(); cyc(); cyc();
    check_val("hold_rgb", {8'h0, rgb_out()}, 32'h00FF00);
    check_val("hold_vld", {31'h0, pix_valid_out}, 32'h0);
    set_pix(1, 0, 4'b0000, 32'h0, 4'd0);
    cyc(); cyc();
    check_val("bg_oob_write_ignored", {8'h0, rgb_out()}, 32'h884048);

`ifdef HIT_FLASH_EN
    pal_write(1'b0, 8'd1, 24'hFF0000);
    set_pix(1, 0, 4'b0001, 32'h0000_0001, 4'd0);
    flash_req = 4'b0001; frame_start = 1'b1;
    cyc();
    flash_req = '0; frame_start = 1'b0;
    cyc(); cyc();
    check_val("flash_on", {8'h0, rgb_out()}, 32'h00FFFF);
    for (int i = 0; i < 8; i++) begin
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      cyc(); cyc(); cyc();
      check_val("flash_frame", {8'h0, rgb_out()}, (i < 7) ? 32'h00FFFF : 32'hFF0000);
    end
`endif

    // Asynchronous reset mid-stream
    set_pix(1, 0, 4'b0000, 32'h0, 4'd0);
    cyc(); cyc();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_rgb", {8'h0, rgb_out()}, 32'h0);
    check_val("arst_vld", {31'h0, pix_valid_out}, 32'h0);
    @(posedge Clk); @(posedge Clk);
    #3 Reset_n = 1'b1;
    cyc(); cyc();
    check_val("post_reset_bg", {8'h0, rgb_out()}, 32'h0);
    check_val("post_reset_vld", {31'h0, pix_valid_out}, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      pix_valid_in = ($urandom % 8) != 0;
      blank_in     = ($urandom % 10) == 0;
      layer_hit    = 4'($urandom);
      for (int k = 0; k < 4; k++) layer_idx[k*8 +: 8] = 8'($urandom_range(0, 20));
      if ($urandom % 50 == 0) layer_idx[7:0] = 8'hFF;
      bg_idx       = 4'($urandom);
      pal_we       = ($urandom % 4) == 0;
      pal_sel      = 1'($urandom);
      pal_addr     = 8'($urandom_range(0, 20));
      pal_wdata    = 24'($urandom);
      flash_req    = (($urandom % 16) == 0) ? 4'($urandom) : 4'h0;
      frame_start  = ($urandom % 5) == 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
